rv_dmem_responder: RTL

RV_DMEM_RESPONDER -- requirements
Module: rv_dmem_responder

---
 rtl/rv_pkg.sv | 11 +
 rtl/rv_dmem_array.sv | 29 ++
 rtl/rv_dmem_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared defaults and state type for the data-memory responder
package rv_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_rsp_state_t;
endpackage

// File: rtl/rv_dmem_array.sv
// rtl/rv_dmem_array.sv - word storage with asynchronous read and byte-enabled synchronous write
module rv_dmem_array
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [IDX_W-1:0]        idx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   assign rdata = mem[idx];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end
endmodule

// File: rtl/rv_dmem_responder.sv
// rtl/rv_dmem_responder.sv - fixed-latency single-outstanding data-memory responder with
// range/alignment checking in front of rv_dmem_array
module rv_dmem_responder
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic                    req_wr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_be_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o
);
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int WI_W  = ADDR_WIDTH - 2;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_rsp_state_t         state;
   logic [CNT_W-1:0]        cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    wr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] be_q;
   logic [WI_W-1:0]         word_idx;
   logic                    acc_err;
   logic                    do_access;
   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   assign req_ready_o = (state == IDLE);
   assign word_idx    = addr_q[ADDR_WIDTH-1:2];
   assign acc_err     = (addr_q[1:0] != 2'b00) || (word_idx >= WI_W'(DEPTH_WORDS));
   assign do_access   = (state == WAIT) && (cnt == '0);
   // A reset landing on the completion edge must drop the pending write.
   assign mem_we      = do_access && wr_q && !acc_err && !rst;

   rv_dmem_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .be    (be_q),
      .idx   (addr_q[IDX_W+1:2]),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  addr_q  <= req_addr_i;
                  wr_q    <= req_wr_i;
                  wdata_q <= req_wdata_i;
                  be_q    <= req_be_i;
                  cnt     <= CNT_W'(LATENCY - 1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= acc_err;
                  rsp_rdata_o <= (acc_err || wr_q) ? '0 : mem_rdata;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
